ro_puf_sequencer: RTL and testbench
===================================

// Module: ro_puf_sequencer
// PURPOSE
//  Parametrised successor to the ring-oscillator PUF state machine. Measures the loops selected by a
//  challenge mask, repeated a run-time number of times, and majority-votes each loop's comparator bit.
//  Delivers the NUM_LOOPS-bit response over a valid/ready handshake.
//  Sits between the host/UART command path and the RO array + counter/comparator datapath.
// PARAMETERS
//  NUM_LOOPS        4   number of selectable RO loops (>=2); also the response width
//  REPETITIONS_BITS 16  width of repetitions input and of each per-loop vote counter
//  EVAL_TIME_BITS   16  width of eval_time input
//  SETTLE_CYCLES    2   cycles reset_puf is held before each evaluation (>=1)
//  SEL_W            $clog2(NUM_LOOPS)  select_puf width (derived localparam, min 1)
// PORTS
//  clk                 in   1                 system clock, all logic on posedge
//  reset               in   1                 synchronous, active-high
//  start               in   1                 request a run; sampled only in IDLE
//  abort               in   1                 cancel the run in progress
//  challenge           in   NUM_LOOPS         loop-enable mask; bit i=1 measures loop i
//  repetitions         in   REPETITIONS_BITS  measurement passes per loop
//  eval_time           in   EVAL_TIME_BITS    enable_puf high time per measurement, in cycles
//  resp_bit            in   1                 comparator result from the datapath; sampled in STORE
//  busy                out  1                 high in every state except IDLE
//  done                out  1                 one-cycle pulse on the cycle resp_valid first rises
//  reset_puf           out  1                 clears the RO counters (high in RST)
//  select_puf          out  SEL_W             loop under measurement
//  enable_puf          out  1                 RO enable (high in EVAL)
//  store_response_puf  out  1                 comparator capture strobe (high in STORE)
//  resp_valid          out  1                 response available
//  resp_ready          in   1                 consumer accepts the response
//  response            out  NUM_LOOPS         voted response; stable while resp_valid=1
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE; all outputs 0; vote counters and response cleared. Reset wins over abort.
//  States: IDLE -> RST -> EVAL -> STORE -> (RST | RESP) -> IDLE.
//  IDLE: on start=1, latch challenge, repetitions and eval_time.
//   - A latched value of 0 for repetitions or eval_time is treated as 1.
//   - Clear all vote counters.
//   - If mask==0, go directly to RESP with response=0. Otherwise go to RST with select_puf = lowest set mask bit.
//  RST: reset_puf=1 for exactly SETTLE_CYCLES cycles, then EVAL.
//  EVAL: enable_puf=1 for exactly eval_time cycles, then STORE.
//  STORE: store_response_puf=1 for 1 cycle. Sample resp_bit and add it to vote counter[select_puf].
//   Then advance to the next set mask bit in ascending order and go to RST.
//   After the highest set bit, increment the pass count.
//   If passes remain, restart at the lowest set bit and go to RST; otherwise go to RESP.
//  Order: repetition is the outer loop, loop index the inner loop.
//  select_puf is constant from RST through STORE of a measurement and reads 0 in IDLE.
//  Vote: response[i] = mask[i] && (2*ones[i] > reps). A tie gives 0; unmasked bits are 0.
//   Compute 2*ones at REPETITIONS_BITS+1 width; no overflow is possible.
//  RESP: resp_valid=1 and response is held. done pulses on the entry cycle only.
//   On resp_valid && resp_ready, go to IDLE next cycle with resp_valid=0.
//   A new run may start on the cycle after that.
//  Latency: with M set mask bits and R passes, start sampled at edge k gives resp_valid at edge
//   k + M*R*(SETTLE_CYCLES+eval_time+1) + 1. For mask==0, resp_valid rises at edge k+1.
//  start outside IDLE: ignored. Inputs changing mid-run: no effect (latched copies are used).
//  abort in RST/EVAL/STORE: next cycle IDLE, strobes 0, no response, no done.
//   abort in RESP: response is discarded, resp_valid drops next cycle.
//   abort in IDLE: no effect.
// TESTING
//  1. Reset held 20 cycles, then released -> all outputs 0, busy=0. start while reset=1 is ignored.
//  2. SETTLE=2, eval=8, reps=2, mask=4'b1111, resp_bit=1 -> select order 0,1,2,3,0,1,2,3.
//     Each measurement is 2 RST + 8 EVAL + 1 STORE cycles; resp_valid and done rise 89 cycles after start.
//     response=4'b1111.
//  3. reps=3, mask=4'b0101, resp_bit pattern L0:1,0,1 and L2:0,0,1 -> loops 1 and 3 never selected; response=4'b0001.
//     Repeat with reps=2, L0:1,0 -> tie, response[0]=0.
//  4. mask=0 -> resp_valid at edge k+1, response=0, no reset_puf/enable_puf activity.
//     eval_time=0 -> exactly 1 EVAL cycle.
//  5. resp_ready held 0 for 10 cycles -> response and resp_valid stable, done pulses once.
//     A start during that window is ignored. resp_ready=1 -> IDLE next cycle.
//  6. abort on the 3rd EVAL cycle -> IDLE next cycle, no done. A following normal run gives correct votes
//     (counters were cleared).
//     Reset asserted mid-EVAL -> IDLE next cycle.

Source files
------------

// File: rtl/ro_puf_sequencer_if.sv
// ro_puf_sequencer_if: host command/response handshake plus RO datapath strobes for the PUF sequencer.
interface ro_puf_sequencer_if #(
    parameter int NUM_LOOPS        = 4,
    parameter int REPETITIONS_BITS = 16,
    parameter int EVAL_TIME_BITS   = 16
);
    localparam int SEL_W = NUM_LOOPS > 2 ? $clog2(NUM_LOOPS) : 1;
    logic                        start;
    logic                        abort;
    logic [NUM_LOOPS-1:0]        challenge;
    logic [REPETITIONS_BITS-1:0] repetitions;
    logic [EVAL_TIME_BITS-1:0]   eval_time;
    logic                        resp_bit;
    logic                        busy;
    logic                        done;
    logic                        reset_puf;
    logic [SEL_W-1:0]            select_puf;
    logic                        enable_puf;
    logic                        store_response_puf;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [NUM_LOOPS-1:0]        response;
    modport master (
        output start, abort, challenge, repetitions, eval_time, resp_bit, resp_ready,
        input  busy, done, reset_puf, select_puf, enable_puf, store_response_puf, resp_valid, response
    );
    modport slave (
        input  start, abort, challenge, repetitions, eval_time, resp_bit, resp_ready,
        output busy, done, reset_puf, select_puf, enable_puf, store_response_puf, resp_valid, response
    );
endinterface

// File: rtl/ro_puf_sequencer.sv
// ro_puf_sequencer: measures challenge-selected RO loops over several passes and majority-votes each loop.
module ro_puf_sequencer #(
    parameter int NUM_LOOPS        = 4,
    parameter int REPETITIONS_BITS = 16,
    parameter int EVAL_TIME_BITS   = 16,
    parameter int SETTLE_CYCLES    = 2
) (
    input logic              clk,
    input logic              reset,
    ro_puf_sequencer_if.slave bus
);
    localparam int SEL_W = NUM_LOOPS > 2 ? $clog2(NUM_LOOPS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CW    = EVAL_TIME_BITS > SET_W ? EVAL_TIME_BITS : SET_W;
    localparam int RB    = REPETITIONS_BITS;
    typedef enum logic [2:0] {IDLE, RST, EVAL, STORE, RESP} state_e;
    state_e                        state_q, state_d;
    logic [NUM_LOOPS-1:0]          mask_q, mask_d, resp_q, resp_d;
    logic [RB-1:0]                 reps_q, reps_d, pass_q, pass_d;
    logic [EVAL_TIME_BITS-1:0]     eval_q, eval_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [SEL_W-1:0]              sel_q, sel_d;
    logic [NUM_LOOPS-1:0][RB-1:0]  votes_q, votes_d;
    logic                          done_q, done_d;
    logic [SEL_W:0]                first_bit, restart_bit, next_bit;
    logic                          phase_end;
    // {found, index} of the lowest set mask bit at or above lo
    function automatic logic [SEL_W:0] lowest_from(input logic [NUM_LOOPS-1:0] m, input int lo);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = NUM_LOOPS - 1; i >= 0; i--)
            if (m[i] && i >= lo) r = {1'b1, SEL_W'(i)};
        return r;
    endfunction
    assign first_bit   = lowest_from(bus.challenge, 0);
    assign restart_bit = lowest_from(mask_q, 0);
    assign next_bit    = lowest_from(mask_q, int'(sel_q) + 1);
    assign phase_end   = cnt_q == (state_q == RST ? CW'(SETTLE_CYCLES - 1) : CW'(eval_q - 1'b1));
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        reps_d  = reps_q;
        eval_d  = eval_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        pass_d  = pass_q;
        votes_d = votes_q;
        resp_d  = resp_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                mask_d  = bus.challenge;
                reps_d  = bus.repetitions == '0 ? RB'(1) : bus.repetitions;
                eval_d  = bus.eval_time == '0 ? EVAL_TIME_BITS'(1) : bus.eval_time;
                votes_d = '0;
                pass_d  = '0;
                cnt_d   = '0;
                resp_d  = '0;
                sel_d   = first_bit[SEL_W-1:0];
                state_d = first_bit[SEL_W] ? RST : RESP;
                done_d  = !first_bit[SEL_W];
            end
            RST, EVAL: begin
                cnt_d = cnt_q + 1'b1;
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = state_q == RST ? EVAL : STORE;
                end
            end
            STORE: begin
                votes_d[sel_q] = votes_q[sel_q] + RB'(bus.resp_bit);
                state_d = RST;
                sel_d   = next_bit[SEL_W] ? next_bit[SEL_W-1:0] : restart_bit[SEL_W-1:0];
                if (!next_bit[SEL_W]) begin
                    pass_d = pass_q + 1'b1;
                    if (pass_d == reps_q) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        sel_d   = '0;
                        for (int i = 0; i < NUM_LOOPS; i++)
                            resp_d[i] = mask_q[i] && ({votes_d[i], 1'b0} > {1'b0, reps_q});
                    end
                end
            end
            RESP: if (bus.resp_ready) begin
                state_d = IDLE;
                resp_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            resp_d  = '0;
            done_d  = 1'b0;
            sel_d   = '0;
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            reps_q  <= '0;
            eval_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            pass_q  <= '0;
            votes_q <= '0;
            resp_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            reps_q  <= reps_d;
            eval_q  <= eval_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pass_q  <= pass_d;
            votes_q <= votes_d;
            resp_q  <= resp_d;
            done_q  <= done_d;
        end
    end
    assign bus.busy               = state_q != IDLE;
    assign bus.done               = done_q;
    assign bus.reset_puf          = state_q == RST;
    assign bus.enable_puf         = state_q == EVAL;
    assign bus.store_response_puf = state_q == STORE;
    assign bus.resp_valid         = state_q == RESP;
    assign bus.select_puf         = sel_q;
    assign bus.response           = resp_q;
endmodule

// File: tb/tb_ro_puf_sequencer.sv
// tb_ro_puf_sequencer: directed scenarios for the RO PUF sequencer with hand-computed votes and latencies.
module tb_ro_puf_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          fails = 0;
    int          lat, meas, rst_cyc, eval_cyc;
    logic        done_first;
    logic [63:0] seq;
    logic [31:0] bit_pat;
    always #5 clk = ~clk;
    ro_puf_sequencer_if bus ();
    ro_puf_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end
    function automatic logic [11:0] outs();
        return {bus.busy, bus.done, bus.reset_puf, bus.enable_puf, bus.store_response_puf,
                bus.resp_valid, bus.select_puf, bus.response};
    endfunction
    // start is sampled at the posedge after this negedge; inputs are scrambled afterwards
    task automatic launch(input logic [3:0] m, input logic [15:0] r, input logic [15:0] e, input logic [31:0] bits);
        @(negedge clk);
        bit_pat = bits;
        bus.challenge = m;
        bus.repetitions = r;
        bus.eval_time = e;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.challenge = ~m;
        bus.repetitions = r + 16'd3;
        bus.eval_time = e + 16'd5;
    endtask
    // lat = index of the first edge (after the start edge) that samples resp_valid=1
    task automatic collect(input int limit);
        lat = 1;
        meas = 0;
        rst_cyc = 0;
        eval_cyc = 0;
        seq = '0;
        done_first = 1'b0;
        while (lat <= limit) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                done_first = bus.done;
                break;
            end
            rst_cyc += int'(bus.reset_puf);
            eval_cyc += int'(bus.enable_puf);
            if (bus.store_response_puf) begin
                seq = {seq[59:0], 4'(bus.select_puf)};
                bus.resp_bit = bit_pat[meas % 32];
                meas++;
            end
            @(posedge clk);
            lat++;
        end
    endtask
    task automatic accept();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask
    task automatic test_reset();
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.challenge = 4'hF;
        bus.repetitions = 16'd1;
        bus.eval_time = 16'd1;
        bus.resp_bit = 1'b0;
        bus.resp_ready = 1'b0;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs() !== 12'h000) begin fails++; $display("FAIL reset_outputs: got %h expected %h", outs(), 12'h000); end
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 12'h000) begin fails++; $display("FAIL post_reset_idle: got %h expected %h", outs(), 12'h000); end
    endtask
    task automatic test_full_run();
        launch(4'hF, 16'd2, 16'd8, 32'hFFFF_FFFF);
        collect(200);
        checks++;
        if (lat != 89) begin fails++; $display("FAIL full_latency: got %0d expected 89", lat); end
        checks++;
        if (seq !== 64'h0123_0123) begin fails++; $display("FAIL full_select_order: got %h expected %h", seq, 64'h0123_0123); end
        checks++;
        if (rst_cyc != 16) begin fails++; $display("FAIL full_rst_cycles: got %0d expected 16", rst_cyc); end
        checks++;
        if (eval_cyc != 64) begin fails++; $display("FAIL full_eval_cycles: got %0d expected 64", eval_cyc); end
        checks++;
        if (done_first !== 1'b1) begin fails++; $display("FAIL full_done: got %b expected 1", done_first); end
        checks++;
        if (bus.response !== 4'hF) begin fails++; $display("FAIL full_response: got %b expected 1111", bus.response); end
        accept();
        checks++;
        if ({bus.busy, bus.resp_valid} !== 2'b00) begin fails++; $display("FAIL full_accept_idle: got %b expected 00", {bus.busy, bus.resp_valid}); end
    endtask
    task automatic test_votes();
        launch(4'b0101, 16'd3, 16'd1, 32'b11_0001);
        collect(100);
        checks++;
        if (lat != 25) begin fails++; $display("FAIL vote3_latency: got %0d expected 25", lat); end
        checks++;
        if (seq !== 64'h02_0202) begin fails++; $display("FAIL vote3_select_order: got %h expected %h", seq, 64'h02_0202); end
        checks++;
        if (bus.response !== 4'b0001) begin fails++; $display("FAIL vote3_response: got %b expected 0001", bus.response); end
        accept();
        launch(4'b0101, 16'd2, 16'd1, 32'b1011);
        collect(100);
        checks++;
        if (bus.response !== 4'b0100) begin fails++; $display("FAIL vote_tie_response: got %b expected 0100", bus.response); end
        accept();
    endtask
    task automatic test_edges();
        launch(4'b0000, 16'd5, 16'd5, 32'h0);
        collect(20);
        checks++;
        if (lat != 1) begin fails++; $display("FAIL mask0_latency: got %0d expected 1", lat); end
        checks++;
        if (rst_cyc + eval_cyc != 0) begin fails++; $display("FAIL mask0_activity: got %0d expected 0", rst_cyc + eval_cyc); end
        checks++;
        if ({done_first, bus.response} !== 5'b1_0000) begin fails++; $display("FAIL mask0_done_response: got %b expected 10000", {done_first, bus.response}); end
        accept();
        launch(4'b0010, 16'd0, 16'd0, 32'h1);
        collect(50);
        checks++;
        if (eval_cyc != 1) begin fails++; $display("FAIL eval0_cycles: got %0d expected 1", eval_cyc); end
        checks++;
        if (lat != 5) begin fails++; $display("FAIL eval0_reps0_latency: got %0d expected 5", lat); end
        checks++;
        if ({seq[3:0], bus.response} !== 8'h12) begin fails++; $display("FAIL eval0_select_response: got %h expected 12", {seq[3:0], bus.response}); end
        accept();
    endtask
    task automatic test_hold();
        int bad = 0;
        int dcnt;
        launch(4'b1000, 16'd1, 16'd2, 32'h1);
        collect(50);
        dcnt = int'(done_first);
        checks++;
        if (lat != 6 || bus.response !== 4'b1000) begin fails++; $display("FAIL hold_run: got lat %0d resp %b expected lat 6 resp 1000", lat, bus.response); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = (i >= 3 && i < 6);
            bus.challenge = 4'hF;
            if (!bus.resp_valid || bus.response !== 4'b1000) bad++;
            dcnt += int'(bus.done);
        end
        bus.start = 1'b0;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
        checks++;
        if (dcnt != 1) begin fails++; $display("FAIL hold_done_count: got %0d expected 1", dcnt); end
        accept();
        checks++;
        if ({bus.busy, bus.resp_valid} !== 2'b00) begin fails++; $display("FAIL hold_accept_idle: got %b expected 00", {bus.busy, bus.resp_valid}); end
    endtask
    task automatic test_abort();
        int en = 0;
        int n = 0;
        int bad = 0;
        launch(4'hF, 16'd2, 16'd8, 32'hFFFF_FFFF);
        bus.resp_bit = 1'b1;
        while (en < 19 && n < 300) begin
            @(negedge clk);
            en += int'(bus.enable_puf);
            n++;
        end
        bus.abort = 1'b1;
        checks++;
        if (en != 19) begin fails++; $display("FAIL abort_reach_eval: got %0d eval cycles expected 19", en); end
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (outs() !== 12'h000) begin fails++; $display("FAIL abort_idle: got %h expected %h", outs(), 12'h000); end
        repeat (5) begin
            @(negedge clk);
            bad += int'(bus.done || bus.resp_valid || bus.busy);
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
        launch(4'b0011, 16'd1, 16'd1, 32'h0);
        collect(50);
        checks++;
        if (lat != 9 || bus.response !== 4'b0000) begin fails++; $display("FAIL abort_votes_cleared: got lat %0d resp %b expected lat 9 resp 0000", lat, bus.response); end
        accept();
        launch(4'b0000, 16'd1, 16'd1, 32'h0);
        collect(10);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if ({bus.busy, bus.resp_valid, bus.response} !== 6'h00) begin fails++; $display("FAIL abort_in_resp: got %b expected 000000", {bus.busy, bus.resp_valid, bus.response}); end
        launch(4'b0001, 16'd1, 16'd8, 32'h1);
        n = 0;
        while (!bus.enable_puf && n < 20) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (outs() !== 12'h000) begin fails++; $display("FAIL reset_mid_eval: got %h expected %h", outs(), 12'h000); end
    endtask
    initial begin
        test_reset();
        test_full_run();
        test_votes();
        test_edges();
        test_hold();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
